rs_encoder: RTL and testbench

Systematic RS(255,239) encoder over GF(2^8), t=8. It is the transmit-side counterpart of the decoder chain whose Chien search locates up to 8 error-locator roots. The block accepts K message bytes, passes them through unchanged, then appends 16 parity bytes. The generator polynomial is built in hardware after reset, so the first consecutive root (FCR) is a parameter that must match the decoder's syndrome convention.

---
 rtl/rs_pkg.sv | 32 +++
 rtl/rs_gen_poly.sv | 74 +++++++
 rtl/rs_encoder.sv | 135 +++++++++++++
 tb/tb_rs_encoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rs_pkg : shared GF(2^8) constants, state encoding and gf_mul  rev 1.0
// ------------------------------------------------------------------
package rs_pkg;

  localparam int         NPAR      = 16;
  localparam logic [8:0] PRIM_POLY = 9'h11D;
  localparam logic [7:0] ALPHA     = 8'h02;

  typedef enum logic [1:0] {
    ST_INIT_ROOT = 2'd0,
    ST_INIT_GEN  = 2'd1,
    ST_IDLE      = 2'd2,
    ST_PARITY    = 2'd3
  } state_e;

  // Shift-and-reduce multiply: one partial product per bit of b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_gen_poly.sv
`default_nettype none
// ------------------------------------------------------------------
// rs_gen_poly : builds g(x) = prod (x + a^(FCR+i)), i=0..15     rev 1.0
// ------------------------------------------------------------------
module rs_gen_poly
  import rs_pkg::*;
#(
  parameter int FCR = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NPAR*8-1:0]   g_flat,
  output logic                last_step
);

  localparam logic [8:0] FCR_STEPS = 9'(FCR);
  localparam logic [8:0] LAST_STEP = 9'(FCR + NPAR - 1);

  logic [8:0] step_q, step_d;
  logic       done_q, done_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q [NPAR];
  logic [7:0] g_d [NPAR];
  logic       in_root;

  // The first FCR steps only advance the root towards a^FCR.
  generate
    if (FCR == 0) begin : g_no_root
      assign in_root = 1'b0;
    end else begin : g_root
      assign in_root = (step_q < FCR_STEPS);
    end
  endgenerate

  always_comb begin
    step_d = step_q;
    done_d = done_q;
    r_d    = r_q;
    for (int j = 0; j < NPAR; j++) g_d[j] = g_q[j];
    if (!done_q) begin
      step_d = step_q + 9'd1;
      r_d    = gf_mul(r_q, ALPHA);
      if (!in_root) begin
        g_d[0] = gf_mul(g_q[0], r_q);
        for (int j = 1; j < NPAR; j++) g_d[j] = g_q[j-1] ^ gf_mul(g_q[j], r_q);
      end
      if (step_q == LAST_STEP) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
      done_q <= 1'b0;
      r_q    <= 8'h01;
      for (int j = 0; j < NPAR; j++) g_q[j] <= (j == 0) ? 8'h01 : 8'h00;
    end else begin
      step_q <= step_d;
      done_q <= done_d;
      r_q    <= r_d;
      for (int j = 0; j < NPAR; j++) g_q[j] <= g_d[j];
    end
  end

  assign last_step = !done_q && (step_q == LAST_STEP);

  generate
    for (genvar j = 0; j < NPAR; j++) begin : g_pack
      assign g_flat[j*8 +: 8] = g_q[j];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rs_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// rs_encoder : systematic RS(255,239) encoder, 16 parity bytes  rev 1.0
// ------------------------------------------------------------------
module rs_encoder
  import rs_pkg::*;
#(
  parameter int K   = 239,
  parameter int FCR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       CEO,
  output logic [7:0] data_out,
  output logic       first,
  output logic       last
);

  localparam logic [7:0] LAST_MSG = 8'(K - 1);
  localparam logic [7:0] LAST_PAR = 8'(NPAR - 1);

  logic [NPAR*8-1:0] g_flat;
  logic              gen_last;
  logic [7:0]        g [NPAR];

  rs_gen_poly #(.FCR(FCR)) u_gen (
    .clk       (clk),
    .reset     (reset),
    .g_flat    (g_flat),
    .last_step (gen_last)
  );

  generate
    for (genvar j = 0; j < NPAR; j++) begin : g_unpack
      assign g[j] = g_flat[j*8 +: 8];
    end
  endgenerate

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic       ceo_q, ceo_d;
  logic [7:0] dout_q, dout_d;
  logic       first_q, first_d;
  logic       last_q, last_d;
  logic [7:0] b_q, b_d;
  logic [7:0] p_q [NPAR];
  logic [7:0] p_d [NPAR];
  logic [7:0] fb;

  assign fb = data_in ^ p_q[NPAR-1];

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    ceo_d   = 1'b0;
    dout_d  = dout_q;
    first_d = 1'b0;
    last_d  = 1'b0;
    b_d     = b_q;
    for (int j = 0; j < NPAR; j++) p_d[j] = p_q[j];
    case (state_q)
      ST_INIT_ROOT, ST_INIT_GEN: begin
        if (gen_last) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (CE) begin
          p_d[0] = gf_mul(fb, g[0]);
          for (int j = 1; j < NPAR; j++) p_d[j] = p_q[j-1] ^ gf_mul(fb, g[j]);
          dout_d  = data_in;
          ceo_d   = 1'b1;
          first_d = (b_q == 8'd0);
          if (b_q == LAST_MSG) begin
            state_d = ST_PARITY;
            ready_d = 1'b0;
            b_d     = 8'd0;
          end else begin
            b_d = b_q + 8'd1;
          end
        end
      end
      ST_PARITY: begin
        // Shifting out also leaves the register cleared for the next frame.
        dout_d = p_q[NPAR-1];
        ceo_d  = 1'b1;
        for (int j = NPAR - 1; j > 0; j--) p_d[j] = p_q[j-1];
        p_d[0] = 8'h00;
        if (b_q == LAST_PAR) begin
          last_d  = 1'b1;
          state_d = ST_IDLE;
          ready_d = 1'b1;
          b_d     = 8'd0;
        end else begin
          b_d = b_q + 8'd1;
        end
      end
      default: state_d = ST_INIT_ROOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT_ROOT;
      ready_q <= 1'b0;
      ceo_q   <= 1'b0;
      dout_q  <= 8'h00;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      b_q     <= 8'd0;
      for (int j = 0; j < NPAR; j++) p_q[j] <= 8'h00;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ceo_q   <= ceo_d;
      dout_q  <= dout_d;
      first_q <= first_d;
      last_q  <= last_d;
      b_q     <= b_d;
      for (int j = 0; j < NPAR; j++) p_q[j] <= p_d[j];
    end
  end

  assign ready    = ready_q;
  assign CEO      = ceo_q;
  assign data_out = dout_q;
  assign first    = first_q;
  assign last     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rs_encoder : checks two encoder instances against a GF model rev 1.0
// ------------------------------------------------------------------
module tb_rs_encoder;

  localparam int K0 = 239;
  localparam int F0 = 0;
  localparam int K1 = 16;
  localparam int F1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce0 = 1'b0, ce1 = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       rdy0, ceo0, f0, l0, rdy1, ceo1, f1, l1;
  logic [7:0] dout0, dout1;

  always #5 clk = ~clk;

  rs_encoder #(.K(K0), .FCR(F0)) dut0 (
    .clk(clk), .reset(rst_n), .CE(ce0), .data_in(din0), .ready(rdy0),
    .CEO(ceo0), .data_out(dout0), .first(f0), .last(l0));

  rs_encoder #(.K(K1), .FCR(F1)) dut1 (
    .clk(clk), .reset(rst_n), .CE(ce1), .data_in(din1), .ready(rdy1),
    .CEO(ceo1), .data_out(dout1), .first(f1), .last(l1));

  typedef struct packed { logic [7:0] d; logic f; logic l; } ob_t;
  ob_t q0[$];
  ob_t q1[$];

  always @(negedge clk) begin
    ob_t e;
    if (ceo0) begin e = '{d: dout0, f: f0, l: l0}; q0.push_back(e); end
    if (ceo1) begin e = '{d: dout1, f: f1, l: l1}; q1.push_back(e); end
  end

  int n_chk = 0;
  int n_err = 0;

  int         exp_t [0:509];
  int         log_t [0:255];
  logic [7:0] genp  [0:1][0:16];
  logic [7:0] msg   [0:238];
  logic [7:0] msg_a [0:238];
  logic [7:0] expp  [0:15];
  logic [7:0] cw    [0:254];
  logic       cf    [0:254];
  logic       cl    [0:254];
  logic [7:0] ref3  [0:254];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Field arithmetic via log/antilog tables of powers of alpha.
  task automatic build_tables();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v; exp_t[i+255] = v; log_t[v] = i;
      v = v << 1;
      if (v >= 256) v = v ^ 'h11D;
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_t[log_t[a] + log_t[b]]);
  endfunction

  // genp[w][d] is the coefficient of x^d of prod (x - a^(fcr+i)).
  task automatic gen_model(input int w, input int fcr);
    logic [7:0] t [0:16];
    logic [7:0] root;
    for (int d = 0; d <= 16; d++) t[d] = (d == 0) ? 8'h01 : 8'h00;
    for (int i = 0; i < 16; i++) begin
      root = 8'(exp_t[(fcr + i) % 255]);
      for (int d = 16; d >= 1; d--) t[d] = t[d-1] ^ gm(t[d], root);
      t[0] = gm(t[0], root);
    end
    for (int d = 0; d <= 16; d++) genp[w][d] = t[d];
  endtask

  // Remainder of m(x)*x^16 divided by g(x), by schoolbook long division.
  task automatic model_parity(input int w, input int k);
    logic [7:0] c [0:254];
    logic [7:0] coef;
    for (int i = 0; i < k + 16; i++) c[i] = (i < k) ? msg[i] : 8'h00;
    for (int i = 0; i < k; i++) begin
      coef = c[i];
      for (int j = 0; j <= 16; j++) c[i+j] = c[i+j] ^ gm(coef, genp[w][16-j]);
    end
    for (int i = 0; i < 16; i++) expp[i] = c[k+i];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input int w, input logic [7:0] d);
    int n;
    n = 0;
    while (((w == 0) ? rdy0 : rdy1) !== 1'b1 && n < 500) begin tick(); n++; end
    if (n >= 500) begin check("ready_wait", 0, 1); return; end
    if (w == 0) begin ce0 = 1'b1; din0 = d; end else begin ce1 = 1'b1; din1 = d; end
    tick();
    if (w == 0) begin ce0 = 1'b0; din0 = 8'($urandom); end
    else begin ce1 = 1'b0; din1 = 8'($urandom); end
  endtask

  task automatic send_frame(input int w, input int k, input bit gaps);
    for (int b = 0; b < k; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      push_byte(w, msg[b]);
    end
    if (gaps) begin
      // CE held high with junk data while the block is busy with parity.
      for (int c = 0; c < 16; c++) begin
        if (w == 0) begin ce0 = 1'b1; din0 = 8'($urandom); end
        else begin ce1 = 1'b1; din1 = 8'($urandom); end
        tick();
      end
      ce0 = 1'b0; ce1 = 1'b0;
    end
  endtask

  task automatic take_frame(input int w, input int k, input string tag, output bit ok);
    int n, sz;
    ob_t e;
    n = 0; ok = 1'b1;
    sz = (w == 0) ? q0.size() : q1.size();
    while (sz < k + 16 && n < 600) begin
      tick(); n++;
      sz = (w == 0) ? q0.size() : q1.size();
    end
    check($sformatf("%s_len", tag), 128'(sz >= k + 16), 1);
    if (sz < k + 16) begin ok = 1'b0; return; end
    for (int i = 0; i < k + 16; i++) begin
      if (w == 0) e = q0.pop_front(); else e = q1.pop_front();
      cw[i] = e.d; cf[i] = e.f; cl[i] = e.l;
    end
  endtask

  task automatic verify(input int w, input int k, input int fcr, input string tag);
    bit ok;
    int nm, np, nf, nl, ns;
    logic [7:0] s, x;
    take_frame(w, k, tag, ok);
    if (!ok) return;
    model_parity(w, k);
    nm = 0; np = 0; nf = 0; nl = 0; ns = 0;
    for (int i = 0; i < k; i++) if (cw[i] !== msg[i]) nm++;
    for (int i = 0; i < 16; i++) if (cw[k+i] !== expp[i]) np++;
    for (int i = 0; i < k + 16; i++) begin
      if (cf[i] !== (i == 0)) nf++;
      if (cl[i] !== (i == k + 15)) nl++;
    end
    for (int j = 0; j < 16; j++) begin
      x = 8'(exp_t[fcr + j]);
      s = 8'h00;
      for (int i = 0; i < k + 16; i++) s = gm(s, x) ^ cw[i];
      if (s != 8'h00) ns++;
    end
    check($sformatf("%s_msg_echo_bad", tag), nm, 0);
    check($sformatf("%s_parity_bad", tag), np, 0);
    check($sformatf("%s_first_bad", tag), nf, 0);
    check($sformatf("%s_last_bad", tag), nl, 0);
    check($sformatf("%s_nonzero_syndromes", tag), ns, 0);
  endtask

  task automatic measure_ready(input string tag);
    int t0, t1;
    t0 = -1; t1 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rdy0 === 1'b1 && t0 < 0) t0 = c;
      if (rdy1 === 1'b1 && t1 < 0) t1 = c;
    end
    check($sformatf("%s_ready0_latency", tag), 128'(t0), 128'(F0 + 16));
    check($sformatf("%s_ready1_latency", tag), 128'(t1), 128'(F1 + 16));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] want;
    int n, d3;
    build_tables();
    gen_model(0, F0);
    gen_model(1, F1);

    // Scenario 1: reset values, init latency, generator contents
    repeat (3) tick();
    check("reset_outputs0", {rdy0, ceo0, dout0, f0, l0}, 0);
    check("reset_outputs1", {rdy1, ceo1, dout1, f1, l1}, 0);
    rst_n = 1'b1;
    measure_ready("init");
    want = '0;
    for (int j = 0; j < 16; j++) want[j*8 +: 8] = genp[0][j];
    check("gen_poly0", dut0.u_gen.g_flat, want);
    check("gen_g0_alpha120", dut0.u_gen.g_flat[7:0], 128'(exp_t[120]));
    want = '0;
    for (int j = 0; j < 16; j++) want[j*8 +: 8] = genp[1][j];
    check("gen_poly1", dut1.u_gen.g_flat, want);

    // Scenario 2: all-zero message, ready low for 16 cycles after last byte
    for (int i = 0; i < K0; i++) msg[i] = 8'h00;
    send_frame(0, K0, 1'b0);
    n = 0;
    while (rdy0 !== 1'b1 && n < 100) begin n++; tick(); end
    check("zero_ready_low_cycles", n, 16);
    verify(0, K0, F0, "zero");

    // Scenario 3: counting message
    for (int i = 0; i < K0; i++) msg[i] = 8'(i + 1);
    send_frame(0, K0, 1'b0);
    verify(0, K0, F0, "count");
    for (int i = 0; i < K0 + 16; i++) ref3[i] = cw[i];

    // Scenario 4: same message with gaps and CE held during parity
    send_frame(0, K0, 1'b1);
    verify(0, K0, F0, "gaps");
    d3 = 0;
    for (int i = 0; i < K0 + 16; i++) if (cw[i] !== ref3[i]) d3++;
    check("gaps_vs_count_diff", d3, 0);
    repeat (3) tick();
    check("gaps_no_extra_output", q0.size(), 0);

    // Scenario 5: two back-to-back K=16 frames, FCR=1
    for (int i = 0; i < K1; i++) msg[i] = 8'($urandom);
    send_frame(1, K1, 1'b0);
    for (int i = 0; i < K1; i++) msg_a[i] = msg[i];
    for (int i = 0; i < K1; i++) msg[i] = 8'($urandom);
    send_frame(1, K1, 1'b0);
    for (int i = 0; i < K1; i++) begin
      logic [7:0] t;
      t = msg[i]; msg[i] = msg_a[i]; msg_a[i] = t;
    end
    verify(1, K1, F1, "b2b_f1");
    for (int i = 0; i < K1; i++) msg[i] = msg_a[i];
    verify(1, K1, F1, "b2b_f2");
    repeat (3) tick();
    check("b2b_pulse_count_extra", q1.size(), 0);

    // Scenario 6: reset during parity byte 5, then re-init and encode
    for (int i = 0; i < K0; i++) msg[i] = 8'($urandom);
    send_frame(0, K0, 1'b0);
    repeat (5) tick();
    check("midparity_ceo", {ceo0, rdy0}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("midparity_reset_outputs", {rdy0, ceo0, dout0, f0, l0}, 0);
    repeat (2) tick();
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    measure_ready("reinit");
    for (int i = 0; i < K0; i++) msg[i] = 8'($urandom);
    send_frame(0, K0, 1'b0);
    verify(0, K0, F0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
